// File: rtl/pipeline_pkg.sv
// Shared encodings for the 5-stage MIPS pipeline.
// Writeback selects, load types and link offset.
package pipeline_pkg;

  localparam logic [1:0] MEMTOREG_ALU  = 2'b00;
  localparam logic [1:0] MEMTOREG_LOAD = 2'b01;
  localparam logic [1:0] MEMTOREG_LINK = 2'b10;

  localparam logic [2:0] LOAD_LW  = 3'b000;
  localparam logic [2:0] LOAD_LB  = 3'b001;
  localparam logic [2:0] LOAD_LBU = 3'b010;
  localparam logic [2:0] LOAD_LH  = 3'b011;
  localparam logic [2:0] LOAD_LHU = 3'b100;

  localparam logic [31:0] LINK_OFFSET = 32'd8;

endpackage

// File: rtl/mem_wb_stage_load_extend.sv
// Little-endian lane select and sign/zero extension of a loaded word.
// Unknown load types fall back to a full-word load.
module load_extend
  import pipeline_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  offset,
  input  logic [2:0]  load_type,
  output logic [31:0] value
);

  logic [31:0] shifted;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign shifted = data >> {offset, 3'b000};
  assign lane_b  = shifted[7:0];
  assign lane_h  = offset[1] ? data[31:16] : data[15:0];

  // Pick the lane and extend it according to the load type
  always_comb begin
    value = data;
    unique case (1'b1)
      (load_type == LOAD_LB):  value = {{24{lane_b[7]}}, lane_b};
      (load_type == LOAD_LBU): value = {24'd0, lane_b};
      (load_type == LOAD_LH):  value = {{16{lane_h[15]}}, lane_h};
      (load_type == LOAD_LHU): value = {16'd0, lane_h};
      default:                 value = data;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register, writeback mux and retire counter.
// Outputs depend only on stage registers, never on mem_* directly.
module mem_wb_stage
  import pipeline_pkg::*;
#(
  parameter int          COUNT_WIDTH = 32,
  parameter logic [31:0] LINK_OFFSET = pipeline_pkg::LINK_OFFSET
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   mem_valid,
  input  logic                   mem_regwrite,
  input  logic [4:0]             mem_writeaddr,
  input  logic [1:0]             mem_memtoreg,
  input  logic [2:0]             mem_load_type,
  input  logic [31:0]            mem_alu_result,
  input  logic [31:0]            mem_load_data,
  input  logic [31:0]            mem_pc,
  output logic                   regwrite,
  output logic [4:0]             writeaddr,
  output logic [31:0]            writedata,
  output logic                   wb_valid,
  output logic [COUNT_WIDTH-1:0] retired
);

  logic        wb_regwrite;
  logic [4:0]  wb_writeaddr;
  logic [1:0]  wb_memtoreg;
  logic [2:0]  wb_load_type;
  logic [31:0] wb_alu_result;
  logic [31:0] wb_load_data;
  logic [31:0] wb_pc;
  logic [31:0] load_value;
  logic        capture;

  assign capture = !flush && !stall;

  // Stage register: flush inserts a cleared bubble, stall holds
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid      <= 1'b0;
      wb_regwrite   <= 1'b0;
      wb_writeaddr  <= '0;
      wb_memtoreg   <= '0;
      wb_load_type  <= '0;
      wb_alu_result <= '0;
      wb_load_data  <= '0;
      wb_pc         <= '0;
    end else if (flush) begin
      wb_valid      <= 1'b0;
      wb_regwrite   <= 1'b0;
      wb_writeaddr  <= '0;
      wb_memtoreg   <= '0;
      wb_load_type  <= '0;
      wb_alu_result <= '0;
      wb_load_data  <= '0;
      wb_pc         <= '0;
    end else if (!stall) begin
      wb_valid      <= mem_valid;
      wb_regwrite   <= mem_regwrite;
      wb_writeaddr  <= mem_writeaddr;
      wb_memtoreg   <= mem_memtoreg;
      wb_load_type  <= mem_load_type;
      wb_alu_result <= mem_alu_result;
      wb_load_data  <= mem_load_data;
      wb_pc         <= mem_pc;
    end
  end

  // Count every valid instruction that enters WB; wraps freely
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired <= '0;
    end else if (capture && mem_valid) begin
      retired <= retired + COUNT_WIDTH'(1);
    end
  end

  load_extend u_load_extend (
    .data      (wb_load_data),
    .offset    (wb_alu_result[1:0]),
    .load_type (wb_load_type),
    .value     (load_value)
  );

  assign regwrite  = wb_valid && wb_regwrite
                   && (wb_writeaddr != 5'd0);
  assign writeaddr = wb_writeaddr;

  // Writeback source select; reserved encoding behaves as ALU
  always_comb begin
    writedata = wb_alu_result;
    unique case (1'b1)
      (wb_memtoreg == MEMTOREG_LOAD): writedata = load_value;
      (wb_memtoreg == MEMTOREG_LINK): writedata = wb_pc + LINK_OFFSET;
      default:                        writedata = wb_alu_result;
    endcase
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register plus writeback logic of the 5-stage MIPS pipeline.
- Captures MEM-stage results each cycle and forms the register-file write port (regwrite, writeaddr, writedata).
- Forms writedata by selecting between ALU result, extended load data and link address.
- Maintains a retired-instruction counter.

Parameters:
- COUNT_WIDTH, 32, width of retired-instruction counter.
- LINK_OFFSET, 8, added to mem_pc for JAL/JALR link value.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  hold MEM/WB contents this cycle.
- flush  input  1  load a bubble this cycle.
- mem_valid  input  1  MEM-stage instruction valid.
- mem_regwrite  input  1  instruction writes a GPR.
- mem_writeaddr  input  5  destination register.
- mem_memtoreg  input  2  writeback select: 00 ALU, 01 load, 10 link, 11 reserved (treated as ALU).
- mem_load_type  input  3  000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU, others treated as LW.
- mem_alu_result  input  32  ALU result / effective address.
- mem_load_data  input  32  aligned word read from data memory.
- mem_pc  input  32  PC of the instruction.
- regwrite  output  1  register-file write enable.
- writeaddr  output  5  register-file write address.
- writedata  output  32  register-file write data.
- wb_valid  output  1  WB stage holds a valid instruction.
- retired  output  COUNT_WIDTH  count of instructions that entered WB.

Behaviour:
- Reset (async, rst=1): all stage registers cleared; wb_valid=0, regwrite=0, writeaddr=0, writedata=0, retired=0. Asserting rst mid-operation discards the held instruction immediately, without waiting for a clock edge.
- Capture priority at each rising edge: flush > stall > load.
  - flush=1: wb_valid<=0. Other fields are don't-care, but are cleared to 0.
  - flush=0, stall=1: all registers hold; no new write is generated. The held write may repeat, which is idempotent.
  - Otherwise: all mem_* fields are registered; wb_valid<=mem_valid.
- Latency: one cycle from MEM inputs to the WB outputs. Outputs are combinational from the stage registers only; there is no combinational path from mem_* to the outputs.
- regwrite = wb_valid & wb_regwrite & (wb_writeaddr != 0).
- writeaddr = registered address, driven regardless of valid.
- writedata selection:
  - memtoreg 00/11: registered alu_result.
  - memtoreg 10: registered pc + LINK_OFFSET, modulo 2^32.
  - memtoreg 01: load extension of registered load_data, using registered alu_result[1:0] as the offset.
- Load extension (little-endian lanes):
  - LB/LBU: byte = data[8*a+7 : 8*a] with a = addr[1:0]; LB sign-extends bit 7 of the byte, LBU zero-extends.
  - LH/LHU: half = addr[1] ? data[31:16] : data[15:0]; addr[0] ignored (misalignment is not trapped here); LH sign-extends, LHU zero-extends.
  - LW: full word; addr[1:0] ignored.
- retired counter:
  - Increments at an edge where flush=0, stall=0 and mem_valid=1.
  - Wraps to 0 after 2^COUNT_WIDTH-1; no saturation.
  - Never increments during stall or flush.
- Simultaneous flush+stall: flush wins, and the bubble is inserted.
- Register-file bypass of the same-cycle write is the register file's job; this block adds no forwarding.

Decomposition:
- Shared package pipeline_pkg holds:
  - MEMTOREG_ALU/LOAD/LINK encodings;
  - LOAD_LW/LB/LBU/LH/LHU encodings;
  - LINK_OFFSET default.
- Natural sub-module: load_extend (combinational) with inputs data[31:0], offset[1:0], load_type[2:0] and output value[31:0]. It is reused by any future cache/LSU path.
- The stage register and counter stay in mem_wb_stage.

Test Plan:
- Reset: rst asserted mid-stream with a valid writing instruction held -> regwrite=0, writedata=0, retired=0 immediately, before any clk edge.
- ALU writeback: mem_valid=1, regwrite=1, addr=5, memtoreg=00, alu_result=0x1234_5678 -> next cycle regwrite=1, writeaddr=5, writedata=0x1234_5678, retired=1. Same inputs with addr=0 -> regwrite=0.
- Byte loads: load_data=0x80FF_7F01.
  - LB with offsets 0/1/2/3 -> 0x0000_0001, 0x0000_007F, 0xFFFF_FFFF, 0xFFFF_FF80.
  - LBU with offset 3 -> 0x0000_0080.
- Half loads: load_data=0x8001_7FFE.
  - LH with addr[1]=1 -> 0xFFFF_8001.
  - LHU with addr[1]=0 -> 0x0000_7FFE.
  - LH with addr=0x...1 behaves as offset 0 -> 0x0000_7FFE.
- Link/wrap: memtoreg=10, mem_pc=0xFFFF_FFFC -> writedata=0x0000_0004.
- Stall/flush:
  - Valid instruction followed by stall=1 for 3 cycles -> outputs constant, retired unchanged.
  - flush=1 together with stall=1 -> wb_valid=0 and regwrite=0 next cycle, retired unchanged.
  - Counter at 2^32-1 plus one more capture -> 0.
